// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control path.
// ALU command codes match what the ALU consumes directly.
package mips_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EXEC,
        S_MUL_WAIT,
        S_R_WB,
        S_IMM_EXEC,
        S_IMM_WB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_MUL = 6'b011000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_OR  = 4'b0111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_mul_wait_counter.sv
// Fixed-latency multiplier wait counter.
// done fires in the CYCLES-th consecutive enabled cycle after a clear.
module mul_wait_counter #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int unsigned W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // cnt_q holds the number of wait cycles already completed
    assign done = en && (cnt_q == W'(CYCLES - 1));

    // next count: clear on entry or completion, else step while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr || done) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/mem/wb and drives all datapath selects.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_cmd,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal
);

    state_e state_q;
    state_e state_d;
    logic   illegal_q;
    logic   illegal_d;
    logic   mul_clr;
    logic   mul_en;
    logic   mul_done;

    mul_wait_counter #(
        .CYCLES (MUL_CYCLES)
    ) u_mul_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mul_clr),
        .en    (mul_en),
        .done  (mul_done)
    );

    assign illegal = illegal_q;

    // state and sticky illegal flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // next-state and per-state output decode
    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        mul_clr       = 1'b0;
        mul_en        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_cmd       = ALU_ADD;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_R:    state_d = S_R_EXEC;
                    OP_LW,
                    OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_J:    state_d = S_JUMP;
                    OP_ADDI,
                    OP_ANDI,
                    OP_ORI:  state_d = S_IMM_EXEC;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                mul_clr   = 1'b1;
                state_d   = S_R_WB;
                case (funct)
                    FN_ADD:  alu_cmd = ALU_ADD;
                    FN_SUB:  alu_cmd = ALU_SUB;
                    FN_AND:  alu_cmd = ALU_AND;
                    FN_OR:   alu_cmd = ALU_OR;
                    FN_MUL: begin
                        alu_cmd = ALU_MUL;
                        state_d = S_MUL_WAIT;
                    end
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MUL_WAIT: begin
                alu_src_a = 1'b1;
                alu_cmd   = ALU_MUL;
                mul_en    = 1'b1;
                if (mul_done) begin
                    state_d = S_R_WB;
                end
            end
            S_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_ANDI: alu_cmd = ALU_AND;
                    OP_ORI:  alu_cmd = ALU_OR;
                    default: alu_cmd = ALU_ADD;
                endcase
                state_d = S_IMM_WB;
            end
            S_IMM_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_cmd       = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl.
// Driver queues hand-computed per-cycle output vectors; monitor compares.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_cmd;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal;

    mips_multicycle_ctrl #(
        .MUL_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_cmd       (alu_cmd),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .instr_done    (instr_done),
        .illegal       (illegal)
    );

    typedef struct {
        logic [19:0] v;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          n_chk;
    int          n_fail;
    logic [19:0] got;

    assign got = {mem_req, mem_we, iord, ir_write, pc_write,
                  pc_write_cond, pc_source, alu_src_a, alu_src_b,
                  alu_cmd, reg_dst, mem_to_reg, reg_write,
                  instr_done, illegal};

    function automatic logic [19:0] ov(
        input logic       req,
        input logic       we,
        input logic       io,
        input logic       irw,
        input logic       pcw,
        input logic       pcc,
        input logic [1:0] psrc,
        input logic       sa,
        input logic [1:0] sbv,
        input logic [3:0] cmd,
        input logic       rd,
        input logic       m2r,
        input logic       rw,
        input logic       dn,
        input logic       ill
    );
        return {req, we, io, irw, pcw, pcc, psrc, sa, sbv, cmd,
                rd, m2r, rw, dn, ill};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: compare one queued expectation per cycle at negedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_chk++;
                if (got !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %05h required %05h",
                             e.nm, got, e.v);
                end
            end
        end
    end

    task automatic s(input logic rst, input logic [5:0] op,
                     input logic [5:0] fn, input logic z,
                     input logic rdy, input logic [19:0] e,
                     input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n     = rst;
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = rdy;
        x.v  = e;
        x.nm = nm;
        sb.push_back(x);
    endtask

    initial begin
        logic [19:0] e_idle, e_fw, e_fr, e_dec, e_maddr, e_mrd;
        logic [19:0] e_mwb, e_mww, e_mwr, e_rsub, e_rmul, e_mul;
        logic [19:0] e_rwb, e_ior, e_iwb, e_br, e_j, e_halt;

        n_chk  = 0;
        n_fail = 0;
        rst_n     = 1'b0;
        opcode    = 6'd0;
        funct     = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        e_idle  = 20'd0;
        e_fw    = ov(1,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0);
        e_fr    = ov(1,0,0,1,1,0,2'b00,0,2'b01,4'b0000,0,0,0,0,0);
        e_dec   = ov(0,0,0,0,0,0,2'b00,0,2'b11,4'b0000,0,0,0,0,0);
        e_maddr = ov(0,0,0,0,0,0,2'b00,1,2'b10,4'b0000,0,0,0,0,0);
        e_mrd   = ov(1,0,1,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0);
        e_mwb   = ov(0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,1,1,1,0);
        e_mww   = ov(1,1,1,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0);
        e_mwr   = ov(1,1,1,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,1,0);
        e_rsub  = ov(0,0,0,0,0,0,2'b00,1,2'b00,4'b0001,0,0,0,0,0);
        e_rmul  = ov(0,0,0,0,0,0,2'b00,1,2'b00,4'b0010,0,0,0,0,0);
        e_mul   = ov(0,0,0,0,0,0,2'b00,1,2'b00,4'b0010,0,0,0,0,0);
        e_rwb   = ov(0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,1,0,1,1,0);
        e_ior   = ov(0,0,0,0,0,0,2'b00,1,2'b10,4'b0111,0,0,0,0,0);
        e_iwb   = ov(0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,1,1,0);
        e_br    = ov(0,0,0,0,0,1,2'b01,1,2'b00,4'b0001,0,0,0,1,0);
        e_j     = ov(0,0,0,0,1,0,2'b10,0,2'b00,4'b0000,0,0,0,1,0);
        e_halt  = ov(0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,1);

        // reset held mid-FETCH, then released
        s(1, 6'h00, 6'h00, 0, 0, e_idle, "reset_idle");
        s(0, 6'h00, 6'h00, 0, 0, e_fw,   "t1_fetch_in_reset");
        s(0, 6'h00, 6'h00, 0, 1, e_idle, "t1_req_dropped");
        s(0, 6'h00, 6'h00, 0, 0, e_idle, "t1_idle_held");
        s(1, 6'h00, 6'h00, 0, 0, e_idle, "t1_idle_release");
        // lw with two-cycle memory stalls
        s(1, 6'h23, 6'h00, 0, 0, e_fw,    "t2_fetch_w1");
        s(1, 6'h23, 6'h00, 0, 0, e_fw,    "t2_fetch_w2");
        s(1, 6'h23, 6'h00, 0, 1, e_fr,    "t2_fetch_rdy");
        s(1, 6'h23, 6'h00, 0, 1, e_dec,   "t2_decode");
        s(1, 6'h23, 6'h00, 0, 0, e_maddr, "t2_mem_addr");
        s(1, 6'h23, 6'h00, 0, 0, e_mrd,   "t2_mem_rd_w1");
        s(1, 6'h23, 6'h00, 0, 0, e_mrd,   "t2_mem_rd_w2");
        s(1, 6'h23, 6'h00, 0, 1, e_mrd,   "t2_mem_rd_rdy");
        s(1, 6'h23, 6'h00, 0, 0, e_mwb,   "t2_mem_wb");
        // R-type sub
        s(1, 6'h00, 6'h22, 0, 1, e_fr,   "t3_fetch");
        s(1, 6'h00, 6'h22, 0, 1, e_dec,  "t3_decode");
        s(1, 6'h00, 6'h22, 0, 1, e_rsub, "t3_r_exec_sub");
        s(1, 6'h00, 6'h22, 0, 1, e_rwb,  "t3_r_wb");
        // multiply, four wait cycles
        s(1, 6'h00, 6'h18, 0, 1, e_fr,   "t4_fetch");
        s(1, 6'h00, 6'h18, 0, 0, e_dec,  "t4_decode");
        s(1, 6'h00, 6'h18, 0, 0, e_rmul, "t4_r_exec_mul");
        for (int i = 0; i < 4; i++) begin
            s(1, 6'h00, 6'h18, 0, 0, e_mul, "t4_mul_wait");
        end
        s(1, 6'h00, 6'h18, 0, 0, e_rwb, "t4_r_wb");
        // sw with one-cycle stall
        s(1, 6'h2b, 6'h00, 0, 1, e_fr,    "sw_fetch");
        s(1, 6'h2b, 6'h00, 0, 0, e_dec,   "sw_decode");
        s(1, 6'h2b, 6'h00, 0, 0, e_maddr, "sw_mem_addr");
        s(1, 6'h2b, 6'h00, 0, 0, e_mww,   "sw_mem_wr_wait");
        s(1, 6'h2b, 6'h00, 0, 1, e_mwr,   "sw_mem_wr_rdy");
        // ori
        s(1, 6'h0d, 6'h00, 0, 1, e_fr,  "ori_fetch");
        s(1, 6'h0d, 6'h00, 0, 0, e_dec, "ori_decode");
        s(1, 6'h0d, 6'h00, 0, 0, e_ior, "ori_exec");
        s(1, 6'h0d, 6'h00, 0, 0, e_iwb, "ori_wb");
        // beq taken / not taken, then j
        s(1, 6'h04, 6'h00, 0, 1, e_fr,  "t5_beq1_fetch");
        s(1, 6'h04, 6'h00, 1, 0, e_dec, "t5_beq1_decode");
        s(1, 6'h04, 6'h00, 1, 0, e_br,  "t5_beq1_branch");
        s(1, 6'h04, 6'h00, 0, 1, e_fr,  "t5_beq0_fetch");
        s(1, 6'h04, 6'h00, 0, 0, e_dec, "t5_beq0_decode");
        s(1, 6'h04, 6'h00, 0, 0, e_br,  "t5_beq0_branch");
        s(1, 6'h02, 6'h00, 0, 1, e_fr,  "t5_j_fetch");
        s(1, 6'h02, 6'h00, 0, 0, e_dec, "t5_j_decode");
        s(1, 6'h02, 6'h00, 0, 0, e_j,   "t5_jump");
        // illegal opcode -> sticky HALT until reset
        s(1, 6'h3f, 6'h00, 0, 1, e_fr,   "t6_fetch");
        s(1, 6'h3f, 6'h00, 0, 1, e_dec,  "t6_decode");
        s(1, 6'h3f, 6'h00, 0, 1, e_halt, "t6_halt1");
        s(1, 6'h3f, 6'h00, 0, 1, e_halt, "t6_halt2");
        s(0, 6'h3f, 6'h00, 0, 1, e_halt, "t6_halt3");
        s(1, 6'h00, 6'h00, 0, 0, e_idle, "t6_reset_idle");
        s(1, 6'h00, 6'h00, 0, 0, e_fw,   "t6_refetch");

        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d left required 0",
                     sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
